// File: rtl/pim_pkg.sv
// Shared constants, helpers and state encodings for the bit-serial accumulator.
package pim_pkg;

   // Result register state: EMPTY means no window result is being held.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'(1) << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

   // Result width large enough for a full window of maximal beats, plus a sign bit.
   function automatic int unsigned calc_out_w(input int unsigned in_w,
                                              input int unsigned bits,
                                              input int unsigned kernal,
                                              input int unsigned sgn);
      return in_w + bits + clog2(kernal * kernal) + sgn;
   endfunction

   // Counter width that never collapses to zero bits.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (clog2(n) > 0) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shift_acc_lane.sv
// One channel: weighted add/subtract of a beat into the accumulator and the held result.
module shift_acc_lane #(
   parameter int unsigned IN_W  = 4,
   parameter int unsigned OUT_W = 12,
   parameter int unsigned SHW   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_accept,
   input  logic             i_last,
   input  logic             i_neg,
   input  logic [SHW-1:0]   i_shift,
   input  logic [IN_W-1:0]  i_value,
   output logic [OUT_W-1:0] o_result
);

   logic [OUT_W-1:0] r_acc;
   logic [OUT_W-1:0] r_result;
   logic [OUT_W-1:0] w_term;
   logic [OUT_W-1:0] w_sum;

   // Plane weight applied to the beat; the sign plane is subtracted in modular arithmetic.
   always_comb begin
      w_term = OUT_W'(i_value) << i_shift;
      w_sum  = i_neg ? (r_acc - w_term) : (r_acc + w_term);
   end

   // Accumulate non-final beats; the final beat lands in the result and restarts the window.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_result <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_accept) begin
         if (i_last) begin
            r_result <= w_sum;
            r_acc    <= '0;
         end else begin
            r_acc <= w_sum;
         end
      end
   end

   assign o_result = r_result;

endmodule

// File: rtl/shift_accumulator.sv
// Bit-serial, MSB-first window accumulator with a one-deep held result per channel.
module shift_accumulator
   import pim_pkg::*;
#(
   parameter  int unsigned KERNAL = 3,
   parameter  int unsigned BITS   = 4,
   parameter  int unsigned IN_W   = 4,
   parameter  int unsigned CH     = 4,
   parameter  int unsigned SIGNED = 0,
   localparam int unsigned OUT_W  = calc_out_w(IN_W, BITS, KERNAL, SIGNED)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH*IN_W-1:0]  in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH*OUT_W-1:0] out_data
);

   localparam int unsigned KK = KERNAL * KERNAL;
   localparam int unsigned BW = cnt_w(BITS);
   localparam int unsigned EW = cnt_w(KK);

   out_state_e      r_state;
   out_state_e      w_state_nxt;
   logic [BW-1:0]   r_bit_cnt;
   logic [EW-1:0]   r_elem_cnt;
   logic            w_last_plane;
   logic            w_last_beat;
   logic            w_accept;
   logic            w_neg;
   logic [BW-1:0]   w_shift;

   // Beat position decode and handshake; a final beat stalls only while the old result is unread.
   always_comb begin
      w_last_plane = (r_bit_cnt == BW'(BITS - 1));
      w_last_beat  = w_last_plane && (r_elem_cnt == EW'(KK - 1));
      in_ready     = !rst && !clr && !((r_state == ST_FULL) && !out_ready && w_last_beat);
      w_accept     = in_valid && in_ready;
      w_neg        = (SIGNED != 0) && (r_bit_cnt == '0);
      w_shift      = BW'(BITS - 1) - r_bit_cnt;
   end

   // Plane and element counters, shared by every lane.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_bit_cnt  <= '0;
         r_elem_cnt <= '0;
      end else if (w_accept) begin
         if (w_last_plane) begin
            r_bit_cnt  <= '0;
            r_elem_cnt <= (r_elem_cnt == EW'(KK - 1)) ? '0 : r_elem_cnt + EW'(1);
         end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
         end
      end
   end

   // Result state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Result state transitions; clr never touches the held result.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept && w_last_beat) w_state_nxt = ST_FULL;
         ST_FULL:  if (out_ready && !(w_accept && w_last_beat)) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   assign out_valid = (r_state == ST_FULL);

   for (genvar c = 0; c < int'(CH); c++) begin : g_lane
      shift_acc_lane #(
         .IN_W  (IN_W),
         .OUT_W (OUT_W),
         .SHW   (BW)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .i_clr    (clr),
         .i_accept (w_accept),
         .i_last   (w_last_beat),
         .i_neg    (w_neg),
         .i_shift  (w_shift),
         .i_value  (in_data[c*IN_W +: IN_W]),
         .o_result (out_data[c*OUT_W +: OUT_W])
      );
   end

endmodule

// File: tb/tb_shift_accumulator.sv
// Directed bench: 1x1 unsigned/signed windows and a 3x3 four-channel instance.
module tb_shift_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Small 1x1 instances (unsigned and signed) share their inputs.
   logic       rst, clr, in_valid, out_ready;
   logic [3:0] in_data;
   logic       u_in_ready, u_out_valid, s_in_ready, s_out_valid;
   logic [7:0] u_out_data;
   logic [8:0] s_out_data;

   // 3x3, four-channel instance.
   logic        k_rst, k_clr, k_in_valid, k_out_ready;
   logic [15:0] k_in_data;
   logic        k_in_ready, k_out_valid;
   logic [47:0] k_out_data;

   shift_accumulator #(.KERNAL(1), .BITS(4), .IN_W(4), .CH(1), .SIGNED(0)) dut_u (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(u_in_ready),
      .in_data(in_data), .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data));

   shift_accumulator #(.KERNAL(1), .BITS(4), .IN_W(4), .CH(1), .SIGNED(1)) dut_s (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data));

   shift_accumulator #(.KERNAL(3), .BITS(4), .IN_W(4), .CH(4), .SIGNED(0)) dut_k (
      .clk(clk), .rst(k_rst), .clr(k_clr), .in_valid(k_in_valid), .in_ready(k_in_ready),
      .in_data(k_in_data), .out_valid(k_out_valid), .out_ready(k_out_ready), .out_data(k_out_data));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One beat into the 1x1 pair.
   task automatic small_beat(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   // One beat into the 3x3 instance, waiting a bounded time for in_ready.
   task automatic k_beat(input logic [15:0] d);
      int guard;
      guard      = 0;
      k_in_valid = 1'b1;
      k_in_data  = d;
      #1;
      while (!k_in_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (!k_in_ready) check_eq("k_beat_ready", 64'(k_in_ready), 64'd1);
      tick();
      k_in_valid = 1'b0;
   endtask

   task automatic k_window(input logic [15:0] d);
      for (int i = 0; i < 36; i++) k_beat(d);
   endtask

   function automatic logic [11:0] k_ch(input logic [47:0] v, input int c);
      return v[c*12 +: 12];
   endfunction

   int ready_cnt;

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      k_rst = 1'b1; k_clr = 1'b0; k_in_valid = 1'b0; k_out_ready = 1'b0; k_in_data = '0;
      tick();
      tick();

      // Reset state
      check_eq("rst_u_valid", 64'(u_out_valid), 64'd0);
      check_eq("rst_u_data", 64'(u_out_data), 64'd0);
      check_eq("rst_u_ready", 64'(u_in_ready), 64'd0);
      check_eq("rst_k_data", 64'(k_out_data), 64'd0);
      rst = 1'b0; k_rst = 1'b0;
      #1;
      check_eq("post_rst_u_ready", 64'(u_in_ready), 64'd1);
      check_eq("post_rst_k_ready", 64'(k_in_ready), 64'd1);
      tick();

      // 1x1 window, beats 1,0,1,1: unsigned 8+2+1=11, signed -8+2+1=-5
      small_beat(4'd1);
      small_beat(4'd0);
      small_beat(4'd1);
      check_eq("u_valid_early", 64'(u_out_valid), 64'd0);
      small_beat(4'd1);
      check_eq("u_valid", 64'(u_out_valid), 64'd1);
      check_eq("u_data_11", 64'(u_out_data), 64'd11);
      check_eq("s_valid", 64'(s_out_valid), 64'd1);
      check_eq("s_data_m5", 64'(s_out_data), 64'h1FB);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("u_consumed", 64'(u_out_valid), 64'd0);

      // Second 1x1 window, beats 0,1,1,0: unsigned 6, signed 6
      small_beat(4'd0);
      small_beat(4'd1);
      small_beat(4'd1);
      small_beat(4'd0);
      check_eq("u_data_6", 64'(u_out_data), 64'd6);
      check_eq("s_data_6", 64'(s_out_data), 64'd6);

      // 3x3 all 15s: 9*15*15 = 2025 per channel
      k_window(16'hFFFF);
      check_eq("k_full_valid", 64'(k_out_valid), 64'd1);
      for (int c = 0; c < 4; c++) check_eq($sformatf("k_2025_ch%0d", c), 64'(k_ch(k_out_data, c)), 64'd2025);

      // Next window overlaps the held result; the final beat stalls until it is consumed
      ready_cnt = 0;
      for (int i = 0; i < 35; i++) begin
         k_in_valid = 1'b1;
         k_in_data  = 16'h1111;
         #1;
         if (k_in_ready) ready_cnt++;
         tick();
      end
      check_eq("k_overlap_accepts", 64'(ready_cnt), 64'd35);
      k_in_valid = 1'b1;
      #1;
      check_eq("k_last_stall", 64'(k_in_ready), 64'd0);
      tick();
      tick();
      check_eq("k_hold_valid", 64'(k_out_valid), 64'd1);
      check_eq("k_hold_data", 64'(k_ch(k_out_data, 2)), 64'd2025);
      k_out_ready = 1'b1;
      #1;
      check_eq("k_last_release", 64'(k_in_ready), 64'd1);
      tick();
      k_in_valid  = 1'b0;
      k_out_ready = 1'b0;
      check_eq("k_reload_valid", 64'(k_out_valid), 64'd1);
      check_eq("k_reload_135", 64'(k_ch(k_out_data, 0)), 64'd135);
      k_out_ready = 1'b1;
      tick();
      k_out_ready = 1'b0;
      check_eq("k_drained", 64'(k_out_valid), 64'd0);

      // Partial window discarded by clr; the clr-cycle beat is refused
      for (int i = 0; i < 10; i++) k_beat(16'h2222);
      k_clr      = 1'b1;
      k_in_valid = 1'b1;
      k_in_data  = 16'hFFFF;
      #1;
      check_eq("k_clr_ready", 64'(k_in_ready), 64'd0);
      tick();
      k_clr      = 1'b0;
      k_in_valid = 1'b0;
      check_eq("k_clr_keeps_empty", 64'(k_out_valid), 64'd0);
      k_window(16'h1111);
      check_eq("k_clr_valid", 64'(k_out_valid), 64'd1);
      check_eq("k_clr_135_ch0", 64'(k_ch(k_out_data, 0)), 64'd135);
      check_eq("k_clr_135_ch3", 64'(k_ch(k_out_data, 3)), 64'd135);

      // Reset mid-window while a result is held
      for (int i = 0; i < 5; i++) k_beat(16'h3333);
      k_rst      = 1'b1;
      k_in_valid = 1'b1;
      #1;
      check_eq("k_rst_ready", 64'(k_in_ready), 64'd0);
      tick();
      k_rst      = 1'b0;
      k_in_valid = 1'b0;
      #1;
      check_eq("k_rst_valid", 64'(k_out_valid), 64'd0);
      check_eq("k_rst_data", 64'(k_out_data), 64'd0);
      check_eq("k_rst_ready_after", 64'(k_in_ready), 64'd1);
      tick();

      // Distinct per-channel values c+1: 135*(c+1)
      k_window(16'h4321);
      for (int c = 0; c < 4; c++) check_eq($sformatf("k_after_rst_ch%0d", c), 64'(k_ch(k_out_data, c)), 64'(135 * (c + 1)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
